// File: rtl/echo_pipe.sv
// echo_pipe: registered, mode-selectable echo path from the digital input bus
// to the analog output pins (pass, programmable delay, sample-and-hold, invert).
module echo_pipe #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 6,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      digital,
  input  logic                     in_valid,
  input  logic [1:0]               mode,
  input  logic [$clog2(DEPTH)-1:0] delay_sel,
  output logic [OUT_WIDTH-1:0]     analog,
  output logic                     out_valid,
  output logic [CNT_WIDTH-1:0]     count
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_DELAY  = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  // Parameter legality is checked while elaborating.
  if (OUT_WIDTH > IN_WIDTH) begin : g_bad_width
    $error("echo_pipe: OUT_WIDTH (%0d) exceeds IN_WIDTH (%0d)", OUT_WIDTH, IN_WIDTH);
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("echo_pipe: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end

  mode_e                 w_mode;
  logic [OUT_WIDTH-1:0]  w_sample;
  logic [OUT_WIDTH-1:0]  w_analog_nxt;
  logic                  w_valid_nxt;

  logic [OUT_WIDTH-1:0]  r_stage_data  [DEPTH];
  logic                  r_stage_valid [DEPTH];
  logic [OUT_WIDTH-1:0]  r_hold;
  logic                  r_hold_seen;
  logic [OUT_WIDTH-1:0]  r_analog;
  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_count;

  assign w_mode   = mode_e'(mode);
  // Only the low OUT_WIDTH bits are carried; the rest are dropped without rounding.
  assign w_sample = digital[OUT_WIDTH-1:0];

  if (IN_WIDTH > OUT_WIDTH) begin : g_drop_upper
    logic w_unused_upper;
    assign w_unused_upper = ^digital[IN_WIDTH-1:OUT_WIDTH];
  end

  // Select the next output sample according to the active mode.
  always_comb begin
    w_analog_nxt = r_analog;
    w_valid_nxt  = r_out_valid;
    unique case (w_mode)
      MODE_PASS: begin
        w_analog_nxt = w_sample;
        w_valid_nxt  = in_valid;
      end
      MODE_DELAY: begin
        w_analog_nxt = r_stage_data[delay_sel];
        w_valid_nxt  = r_stage_valid[delay_sel];
      end
      MODE_HOLD: begin
        w_analog_nxt = r_hold;
        w_valid_nxt  = r_hold_seen;
      end
      MODE_INVERT: begin
        w_analog_nxt = ~w_sample;
        w_valid_nxt  = in_valid;
      end
      default: ;
    endcase
  end

  // Delay line shifts every cycle in every mode; bubbles travel as valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_stage_data[k]  <= '0;
        r_stage_valid[k] <= 1'b0;
      end
    end else begin
      r_stage_data[0]  <= w_sample;
      r_stage_valid[0] <= in_valid;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_stage_data[k]  <= r_stage_data[k-1];
        r_stage_valid[k] <= r_stage_valid[k-1];
      end
    end
  end

  // Hold register captures only on accepted samples while in hold mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_seen <= 1'b0;
    end else if (w_mode == MODE_HOLD && in_valid) begin
      r_hold      <= w_sample;
      r_hold_seen <= 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_analog    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_analog    <= w_analog_nxt;
      r_out_valid <= w_valid_nxt;
    end
  end

  // Saturating count of accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (in_valid && r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign analog    = r_analog;
  assign out_valid = r_out_valid;
  assign count     = r_count;

endmodule

// File: tb/tb_echo_pipe.sv
// Self-checking bench for echo_pipe: directed scenarios plus a randomized run
// compared against a history-based reference model.
module tb_echo_pipe;

  localparam int IW = 12;
  localparam int OW = 6;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] digital;
  logic          in_valid;
  logic [1:0]    mode;
  logic [2:0]    delay_sel;
  logic [OW-1:0] analog;
  logic          out_valid;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model state: history of {sample, valid} (newest first), hold, count.
  logic [OW:0]   hist[$];
  logic [OW-1:0] m_an;
  logic          m_v;
  logic [OW-1:0] m_hold;
  logic          m_seen;
  int            m_cnt;

  echo_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .digital(digital), .in_valid(in_valid), .mode(mode),
    .delay_sel(delay_sel), .analog(analog), .out_valid(out_valid), .count(count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    hist = {};
    for (int i = 0; i < D; i++) hist.push_back('0);
    m_an = '0; m_v = 1'b0; m_hold = '0; m_seen = 1'b0; m_cnt = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_update();
    logic [IW-1:0] d;
    logic [OW-1:0] s;
    logic [OW:0]   tap;
    d = digital;
    s = d[OW-1:0];
    if (rst) begin
      model_clear();
    end else begin
      case (mode)
        2'b00: begin m_an = s;      m_v = in_valid; end
        2'b01: begin tap = hist[delay_sel]; m_an = tap[OW:1]; m_v = tap[0]; end
        2'b10: begin m_an = m_hold; m_v = m_seen; end
        default: begin m_an = ~s;   m_v = in_valid; end
      endcase
      hist.push_front({s, in_valid});
      void'(hist.pop_back());
      if (mode == 2'b10 && in_valid) begin m_hold = s; m_seen = 1'b1; end
      if (in_valid && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; digital = 12'hFFF; mode = 2'b00; delay_sel = '0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (analog !== 6'h00 || out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset: analog=%h valid=%b count=%0d, want 00/0/0", analog, out_valid, count);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_pass();
    mode = 2'b00; digital = 12'hABC; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; digital = 12'h000;
    checks++;
    if (analog !== 6'h3C || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_data: analog=%h valid=%b, want 3c/1", analog, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd1) begin
      errors++;
      $display("FAIL pass_after: valid=%b count=%0d, want 0/1", out_valid, count);
    end
  endtask

  task automatic test_delay();
    int sels[2] = '{3, 7};
    mode = 2'b01;
    foreach (sels[j]) begin
      delay_sel = 3'(sels[j]);
      idle(D + 2);
      digital = 12'h015; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; digital = 12'h3FF;
      for (int i = 1; i <= 12; i++) begin
        if (i == sels[j] + 2) begin
          checks++;
          if (analog !== 6'h15 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL delay_sel%0d_hit: cycle %0d analog=%h valid=%b, want 15/1", sels[j], i, analog, out_valid);
          end
        end else begin
          checks++;
          if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL delay_sel%0d_quiet: cycle %0d valid=%b, want 0", sels[j], i, out_valid);
          end
        end
        tick();
      end
    end
    // Bubble between two samples must survive the line.
    delay_sel = 3'd2;
    idle(D + 2);
    digital = 12'h011; in_valid = 1'b1; tick();
    in_valid = 1'b0; digital = 12'h022; tick();
    digital = 12'h033; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    // outputs appear 4 cycles after each sample: cycle 4 = A, 5 = bubble, 6 = B
    tick();
    checks++;
    if (analog !== 6'h11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bubble_first: analog=%h valid=%b, want 11/1", analog, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_gap: valid=%b, want 0", out_valid);
    end
    tick();
    checks++;
    if (analog !== 6'h33 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bubble_second: analog=%h valid=%b, want 33/1", analog, out_valid);
    end
  endtask

  task automatic test_hold();
    mode = 2'b10;
    digital = 12'h02A; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      digital = 12'($urandom);
      tick();
      checks++;
      if (analog !== 6'h2A || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_steady: cycle %0d analog=%h valid=%b, want 2a/1", i, analog, out_valid);
      end
    end
    digital = 12'h001; in_valid = 1'b1; tick();
    in_valid = 1'b0; digital = 12'hFFF; tick();
    checks++;
    if (analog !== 6'h01 || out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_recapture: analog=%h valid=%b, want 01/1", analog, out_valid);
    end
  endtask

  task automatic test_invert();
    mode = 2'b11;
    digital = 12'h000; in_valid = 1'b1; tick();
    checks++;
    if (analog !== 6'h3F || out_valid !== 1'b1) begin
      errors++; $display("FAIL invert_zero: analog=%h valid=%b, want 3f/1", analog, out_valid);
    end
    digital = 12'hFC0; tick();
    in_valid = 1'b0;
    checks++;
    if (analog !== 6'h3F || out_valid !== 1'b1) begin
      errors++; $display("FAIL invert_upper: analog=%h valid=%b, want 3f/1", analog, out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mode = 2'b00;
    for (int i = 0; i < 20; i++) begin
      digital = 12'($urandom); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0; tick();
    checks++;
    if (count !== 4'd15) begin
      errors++; $display("FAIL saturation: count=%0d, want 15", count);
    end
    // Simultaneous reset and valid: reset wins, nothing counted.
    rst = 1'b1; in_valid = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0; tick();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_vs_valid: count=%0d valid=%b, want 0/0", count, out_valid);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    mode = 2'b01; delay_sel = 3'd7;
    digital = 12'h03C; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 4'd0) begin
        errors++;
        $display("FAIL reset_inflight: cycle %0d valid=%b count=%0d, want 0/0", i, out_valid, count);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) delay_sel = 3'($urandom);
      digital  = 12'($urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (analog !== m_an || out_valid !== m_v || count !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL random: cycle %0d mode=%0d got %h/%b/%0d want %h/%b/%0d",
                 i, mode, analog, out_valid, count, m_an, m_v, m_cnt);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digital = '0; in_valid = 1'b0; mode = 2'b00; delay_sel = '0;
    model_clear();
    test_reset();
    test_pass();
    test_delay();
    test_hold();
    test_invert();
    test_saturation();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
